bit4_mag_comp: RTL and testbench
================================

Name: bit4_mag_comp

Overview:
Registered magnitude comparator for two unsigned operands, A and B, with a default width of 4 bits. It produces one-hot Equal/Greater/Small flags one clock after a valid input. It accepts 7485-style cascade inputs, so several instances can be chained into wider comparators. It is a leaf datapath block used wherever a registered compare result is needed.

Parameters:
WIDTH, 4, operand width in bits (≥1).
SIGNED, 0, 0 = unsigned compare; 1 = two's-complement compare.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  A/B/cascade inputs are sampled on this cycle.
A  input  WIDTH  operand A.
B  input  WIDTH  operand B.
cas_gt  input  1  cascade "greater" from the less-significant stage; tie to 0 standalone.
cas_eq  input  1  cascade "equal" from the less-significant stage; tie to 1 standalone.
cas_lt  input  1  cascade "less" from the less-significant stage; tie to 0 standalone.
out_valid  output  1  flags hold a fresh result.
Equal  output  1  A == B (after cascade resolution).
Greater  output  1  A > B.
Small  output  1  A < B.

Behaviour:
- Reset: on a rising clk with rst=1, the outputs become out_valid=0, Equal=0, Greater=0, Small=0. rst has priority over in_valid.
- Latency: 1 cycle. Inputs are sampled on a clk edge with in_valid=1; the result appears after that edge, and out_valid=1 for exactly that cycle.
- in_valid=0 at an edge: out_valid goes to 0, and Equal/Greater/Small hold their last values.
- Back-to-back in_valid gives one result per cycle. There is no backpressure and no stall.
- Compare rules:
  - SIGNED=0: A and B are treated as unsigned.
  - SIGNED=1: the MSB is the sign bit.
  - A≠B: Greater=(A>B), Small=(A<B), Equal=0.
  - A==B: the result is taken from the cascade inputs with priority cas_eq > cas_gt > cas_lt. If all three cascade inputs are 0, the result is Equal=1.
- After the first valid result, exactly one of Equal/Greater/Small is 1. Before the first valid result, all three are 0.
- Width: there is no overflow. Comparison is done purely on the magnitude or ordering of the WIDTH-bit values. Extremes must work: 0 vs 2^WIDTH−1, and in signed mode the most-negative vs the most-positive value.
- Reset mid-stream: a valid input sampled in the same cycle as rst is discarded, and no result is produced for it.
- The combinational compare is split into a core so that the registered wrapper contains only flops and valid handling.

Decomposition:
- Shared package mag_comp_pkg:
  - a default-width constant (4);
  - a cmp_result_t enum: CMP_LT, CMP_EQ, CMP_GT;
  - a function that maps cmp_result_t to the three one-hot flags.
- One combinational sub-module, mag_comp_core:
  - inputs: A, B, cascade inputs, and the SIGNED parameter;
  - output: cmp_result_t;
  - implemented as an MSB-first bitwise compare chain.
- The top-level bit4_mag_comp registers the core output and generates out_valid.

Test Plan:
- Standalone (cas_eq=1, cas_gt=0, cas_lt=0), in_valid pulsed each cycle with this stimulus sequence:
  - A=0000, B=0000 → next cycle Equal=1, Greater=0, Small=0, out_valid=1.
  - A=0010, B=0000 → Greater=1.
  - A=0010, B=0100 → Small=1.
  - A=0100, B=1000 → Small=1.
- Extremes, unsigned: A=1111, B=0000 → Greater=1; A=0000, B=1111 → Small=1.
- Signed mode (SIGNED=1): A=1000 (−8), B=0111 (+7) → Small=1; A=1111 (−1), B=1110 (−2) → Greater=1.
- Cascade: A=B=0101 with cas_gt=1, cas_eq=0 → Greater=1; with cas_lt=1, cas_eq=0 → Small=1. A=0110, B=0101 with cas_lt=1 → Greater=1 (operands dominate the cascade).
- Valid handling: one in_valid pulse with A=3, B=3, then idle. Required: out_valid is high for exactly 1 cycle, and Equal stays 1 while idle.
- Reset: in the same cycle, assert rst and present a valid A=9, B=2. Next cycle all outputs are 0 and out_valid=0. After releasing rst, a valid A=2, B=9 gives Small=1.

Source files
------------

// File: rtl/mag_comp_pkg.sv
// mag_comp_pkg: shared width default, compare result encoding and flag mapping
package mag_comp_pkg;
  localparam int DEFAULT_WIDTH = 4;
  typedef enum logic [1:0] {CMP_LT, CMP_EQ, CMP_GT} cmp_result_t;
  function automatic logic [2:0] to_flags(input cmp_result_t r);
    return {r == CMP_EQ, r == CMP_GT, r == CMP_LT};
  endfunction
endpackage

// File: rtl/mag_comp_core.sv
// mag_comp_core: combinational MSB-first compare chain with 7485-style cascade resolution
module mag_comp_core
  import mag_comp_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cas_gt,
  input  logic             cas_eq,
  input  logic             cas_lt,
  output cmp_result_t      res
);
  always_comb begin
    res = cas_eq ? CMP_EQ : cas_gt ? CMP_GT : cas_lt ? CMP_LT : CMP_EQ;
    for (int i = 0; i < WIDTH; i++)
      if (a[i] != b[i]) res = (a[i] ^ (SIGNED != 0 && i == WIDTH - 1)) ? CMP_GT : CMP_LT;
  end
endmodule

// File: rtl/bit4_mag_comp.sv
// bit4_mag_comp: registered magnitude comparator with cascade inputs and valid handling
module bit4_mag_comp
  import mag_comp_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cas_gt,
  input  logic             cas_eq,
  input  logic             cas_lt,
  output logic             out_valid,
  output logic             Equal,
  output logic             Greater,
  output logic             Small
);
  cmp_result_t res;
  logic out_valid_d, out_valid_q;
  logic [2:0] flags_d, flags_q;
  mag_comp_core #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_core (
    .a(A), .b(B), .cas_gt(cas_gt), .cas_eq(cas_eq), .cas_lt(cas_lt), .res(res)
  );
  always_comb begin
    out_valid_d = in_valid;
    flags_d = in_valid ? to_flags(res) : flags_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      flags_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      flags_q <= flags_d;
    end
  end
  assign out_valid = out_valid_q;
  assign {Equal, Greater, Small} = flags_q;
endmodule

// File: tb/tb_bit4_mag_comp.sv
// tb_bit4_mag_comp: random and directed checks of unsigned and signed comparators against an arithmetic model
module tb_bit4_mag_comp;
  logic clk = 1'b0;
  logic rst, in_valid, cas_gt, cas_eq, cas_lt;
  logic [3:0] a, b;
  logic ov_u, eq_u, gt_u, lt_u, ov_s, eq_s, gt_s, lt_s;
  logic [3:0] exp_u, exp_s;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  bit4_mag_comp #(.WIDTH(4), .SIGNED(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b),
    .cas_gt(cas_gt), .cas_eq(cas_eq), .cas_lt(cas_lt),
    .out_valid(ov_u), .Equal(eq_u), .Greater(gt_u), .Small(lt_u)
  );
  bit4_mag_comp #(.WIDTH(4), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b),
    .cas_gt(cas_gt), .cas_eq(cas_eq), .cas_lt(cas_lt),
    .out_valid(ov_s), .Equal(eq_s), .Greater(gt_s), .Small(lt_s)
  );
  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got {v,eq,gt,lt}=%b want %b", tag, got, exp);
    end
  endtask
  function automatic logic [2:0] ref_flags(input logic [3:0] x, input logic [3:0] y, input bit sgn,
                                           input logic g, input logic e, input logic l);
    int ix, iy;
    ix = (sgn && x[3]) ? int'(x) - 16 : int'(x);
    iy = (sgn && y[3]) ? int'(y) - 16 : int'(y);
    if (ix > iy) return 3'b010;
    if (ix < iy) return 3'b001;
    if (e) return 3'b100;
    if (g) return 3'b010;
    if (l) return 3'b001;
    return 3'b100;
  endfunction
  task automatic step(input string tag, input logic r, input logic v, input logic [3:0] x, input logic [3:0] y,
                      input logic g, input logic e, input logic l);
    rst = r; in_valid = v; a = x; b = y; cas_gt = g; cas_eq = e; cas_lt = l;
    @(posedge clk);
    #1;
    if (r) begin
      exp_u = '0;
      exp_s = '0;
    end else if (v) begin
      exp_u = {1'b1, ref_flags(x, y, 1'b0, g, e, l)};
      exp_s = {1'b1, ref_flags(x, y, 1'b1, g, e, l)};
    end else begin
      exp_u[3] = 1'b0;
      exp_s[3] = 1'b0;
    end
    chk({tag, "/u"}, {ov_u, eq_u, gt_u, lt_u}, exp_u);
    chk({tag, "/s"}, {ov_s, eq_s, gt_s, lt_s}, exp_s);
  endtask
  initial begin
    exp_u = '0;
    exp_s = '0;
    step("reset0", 1, 0, 0, 0, 0, 1, 0);
    step("reset1", 1, 1, 4'h3, 4'h1, 0, 1, 0);
    step("eq0", 0, 1, 4'b0000, 4'b0000, 0, 1, 0);
    step("gt", 0, 1, 4'b0010, 4'b0000, 0, 1, 0);
    step("lt", 0, 1, 4'b0010, 4'b0100, 0, 1, 0);
    step("lt2", 0, 1, 4'b0100, 4'b1000, 0, 1, 0);
    step("max_vs_0", 0, 1, 4'b1111, 4'b0000, 0, 1, 0);
    step("0_vs_max", 0, 1, 4'b0000, 4'b1111, 0, 1, 0);
    step("neg8_pos7", 0, 1, 4'b1000, 4'b0111, 0, 1, 0);
    step("neg1_neg2", 0, 1, 4'b1111, 4'b1110, 0, 1, 0);
    step("cas_gt", 0, 1, 4'b0101, 4'b0101, 1, 0, 0);
    step("cas_lt", 0, 1, 4'b0101, 4'b0101, 0, 0, 1);
    step("cas_none", 0, 1, 4'b0101, 4'b0101, 0, 0, 0);
    step("cas_eq_pri", 0, 1, 4'b0101, 4'b0101, 1, 1, 1);
    step("cas_gt_pri", 0, 1, 4'b0101, 4'b0101, 1, 0, 1);
    step("op_dom", 0, 1, 4'b0110, 4'b0101, 0, 0, 1);
    step("pulse", 0, 1, 4'd3, 4'd3, 0, 1, 0);
    step("idle1", 0, 0, 4'd7, 4'd1, 0, 1, 0);
    step("idle2", 0, 0, 4'd1, 4'd7, 1, 0, 0);
    step("rst_mid", 1, 1, 4'd9, 4'd2, 0, 1, 0);
    step("post_rst", 0, 1, 4'd2, 4'd9, 0, 1, 0);
    for (int i = 0; i < 400; i++)
      step("rand", ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
           4'($urandom), 4'($urandom_range(0, 3) == 0 ? 0 : $urandom),
           1'($urandom), 1'($urandom), 1'($urandom));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
